// File: rtl/vga_timing.sv
// vga_timing: 640x480-style VGA counters, syncs and frame pulse, all outputs registered.
// Define VGA_TEST_PATTERN_EN to drive colour bars on o_RGB; otherwise o_RGB is tied to 000.
module vga_timing #(
  parameter int CLOCKS_PER_PIXEL = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  output logic       o_Pixel_Enable,
  output logic       o_Horizontal_Sync,
  output logic       o_Vertical_Sync,
  output logic       o_Active,
  output logic [9:0] o_X,
  output logic [9:0] o_Y,
  output logic       o_Frame_Start,
  output logic [2:0] o_RGB
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = CLOCKS_PER_PIXEL > 1 ? $clog2(CLOCKS_PER_PIXEL) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLOCKS_PER_PIXEL - 1);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  // 11-bit bounds so a 1024-wide timing still compares correctly
  localparam logic [10:0] X_ACT = 11'(H_ACTIVE);
  localparam logic [10:0] X_SB = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] X_SE = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] Y_ACT = 11'(V_ACTIVE);
  localparam logic [10:0] Y_SB = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] Y_SE = 11'(V_ACTIVE + V_FRONT + V_SYNC);
  logic [DW-1:0] div;
  logic adv;
  logic act_n;
  logic [9:0] nx;
  logic [9:0] ny;
  logic [10:0] wx;
  logic [10:0] wy;
  always_comb begin
    adv = div == D_LAST;
    nx = adv ? (o_X == X_LAST ? 10'd0 : o_X + 10'd1) : o_X;
    ny = adv && o_X == X_LAST ? (o_Y == Y_LAST ? 10'd0 : o_Y + 10'd1) : o_Y;
    wx = {1'b0, nx};
    wy = {1'b0, ny};
    act_n = wx < X_ACT && wy < Y_ACT;
  end
  // decodes use the next counter values so every output describes the same pixel
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      div <= '0;
      o_X <= X_LAST;
      o_Y <= Y_LAST;
      o_Pixel_Enable <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Active <= 1'b0;
      o_Horizontal_Sync <= 1'b1;
      o_Vertical_Sync <= 1'b1;
    end else begin
      div <= adv ? '0 : div + 1'b1;
      o_X <= nx;
      o_Y <= ny;
      o_Pixel_Enable <= adv;
      o_Frame_Start <= adv && nx == 10'd0 && ny == 10'd0;
      o_Active <= act_n;
      o_Horizontal_Sync <= !(wx >= X_SB && wx < X_SE);
      o_Vertical_Sync <= !(wy >= Y_SB && wy < Y_SE);
    end
  end
`ifdef VGA_TEST_PATTERN_EN
  always_ff @(posedge i_Clock) begin
    o_RGB <= i_Reset ? 3'b000 : (act_n ? nx[9:7] : 3'b000);
  end
`else
  assign o_RGB = 3'b000;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: three vga_timing instances (default, small CPP=3, small CPP=1) checked every
// cycle against a closed-form model derived from the count of edges since reset.
module tb_vga_timing;
  typedef struct packed {
    logic pe;
    logic fs;
    logic act;
    logic hs;
    logic vs;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra = 1'b1, rb = 1'b1, rc = 1'b1;
  int n_vec = 0, n_err = 0;

  logic pe_a, hs_a, vs_a, act_a, fs_a, pe_b, hs_b, vs_b, act_b, fs_b, pe_c, hs_c, vs_c, act_c, fs_c;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic [2:0] rgb_a, rgb_b, rgb_c;
  exp_t ga, gb, gc;
  assign ga = '{pe_a, fs_a, act_a, hs_a, vs_a, x_a, y_a, rgb_a};
  assign gb = '{pe_b, fs_b, act_b, hs_b, vs_b, x_b, y_b, rgb_b};
  assign gc = '{pe_c, fs_c, act_c, hs_c, vs_c, x_c, y_c, rgb_c};

  vga_timing dut_a (
    .i_Clock(clk), .i_Reset(ra), .o_Pixel_Enable(pe_a), .o_Horizontal_Sync(hs_a),
    .o_Vertical_Sync(vs_a), .o_Active(act_a), .o_X(x_a), .o_Y(y_a),
    .o_Frame_Start(fs_a), .o_RGB(rgb_a)
  );

  vga_timing #(
    .CLOCKS_PER_PIXEL(3), .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(5), .H_BACK(4),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_b (
    .i_Clock(clk), .i_Reset(rb), .o_Pixel_Enable(pe_b), .o_Horizontal_Sync(hs_b),
    .o_Vertical_Sync(vs_b), .o_Active(act_b), .o_X(x_b), .o_Y(y_b),
    .o_Frame_Start(fs_b), .o_RGB(rgb_b)
  );

  vga_timing #(
    .CLOCKS_PER_PIXEL(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_c (
    .i_Clock(clk), .i_Reset(rc), .o_Pixel_Enable(pe_c), .o_Horizontal_Sync(hs_c),
    .o_Vertical_Sync(vs_c), .o_Active(act_c), .o_X(x_c), .o_Y(y_c),
    .o_Frame_Start(fs_c), .o_RGB(rgb_c)
  );

  // k = edges since the last edge that sampled reset high; every advance moves one pixel in raster order
  function automatic exp_t model(int k, int cpp, int ha, int hf, int hw, int hb,
                                 int va, int vf, int vw, int vb);
    exp_t e;
    int ht, vt, n, x, y, l;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    n = k / cpp;
    x = ht - 1;
    y = vt - 1;
    if (n > 0) begin
      l = (n - 1) % (ht * vt);
      x = l % ht;
      y = l / ht;
    end
    e.x = 10'(x);
    e.y = 10'(y);
    e.pe = k > 0 && k % cpp == 0;
    e.fs = e.pe && x == 0 && y == 0;
    e.act = x < ha && y < va;
    e.hs = !(x >= ha + hf && x < ha + hf + hw);
    e.vs = !(y >= va + vf && y < va + vf + vw);
`ifdef VGA_TEST_PATTERN_EN
    e.rgb = e.act ? 3'((x >> 7) & 7) : 3'b000;
`else
    e.rgb = 3'b000;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_all(input string who, input exp_t g, input exp_t e);
    check({who, ".pe"}, 32'(g.pe), 32'(e.pe));
    check({who, ".fs"}, 32'(g.fs), 32'(e.fs));
    check({who, ".act"}, 32'(g.act), 32'(e.act));
    check({who, ".hs"}, 32'(g.hs), 32'(e.hs));
    check({who, ".vs"}, 32'(g.vs), 32'(e.vs));
    check({who, ".x"}, 32'(g.x), 32'(e.x));
    check({who, ".y"}, 32'(g.y), 32'(e.y));
    check({who, ".rgb"}, 32'(g.rgb), 32'(e.rgb));
  endtask

  initial begin
    int ka = 0, kb = 0, kc = 0, hs_low = 0, vs_low = 0, last_fs = -1;
    bit vs_done = 0;
    for (int cyc = 0; cyc < 7000; cyc++) begin
      @(posedge clk);
      #1;
      ka = ra ? 0 : ka + 1;
      kb = rb ? 0 : kb + 1;
      kc = rc ? 0 : kc + 1;
      cmp_all("a", ga, model(ka, 4, 640, 16, 96, 48, 480, 10, 2, 33));
      cmp_all("b", gb, model(kb, 3, 20, 3, 5, 4, 6, 2, 2, 3));
      cmp_all("c", gc, model(kc, 1, 8, 2, 3, 2, 4, 1, 2, 2));
      if (ka >= 1 && ka <= 3200 && !hs_a) hs_low++;
      if (ka == 3200) check("a.hsync_cycles", 32'(hs_low), 32'd384);
      if (!vs_done && kb >= 1 && kb <= 1248 && !vs_b) vs_low++;
      if (!vs_done && kb == 1248) begin
        check("b.vsync_cycles", 32'(vs_low), 32'd192);
        vs_done = 1;
      end
      if (rb) last_fs = -1;
      if (fs_b) begin
        if (last_fs >= 0) check("b.frame_period", 32'(cyc - last_fs), 32'd1248);
        last_fs = cyc;
      end
      ra = cyc < 2;
      if (cyc < 3000) begin
        rb = cyc < 2;
        rc = cyc < 2;
      end else begin
        rb = rb ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 299) == 0);
        rc = rc ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 99) == 0);
      end
    end
    if (!vs_done) check("b.vsync_reached", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PIXEL, default 4, i_Clock cycles per pixel (100 MHz -> 25 MHz).
REQ-002 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-003 SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-004 SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-005 SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-006 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-007 SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-008 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-009 SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-010 SHALL have port i_Clock  input  1  single system clock; all logic on its rising edge.
REQ-011 SHALL have port i_Reset  input  1  synchronous, active-high reset.
REQ-012 SHALL have port o_Pixel_Enable  output  1  high in the first i_Clock cycle of each pixel.
REQ-013 SHALL have port o_Horizontal_Sync  output  1  active-low horizontal sync.
REQ-014 SHALL have port o_Vertical_Sync  output  1  active-low vertical sync.
REQ-015 SHALL have port o_Active  output  1  high while the current pixel is visible.
REQ-016 SHALL have port o_X  output  10  current horizontal pixel count.
REQ-017 SHALL have port o_Y  output  10  current line count.
REQ-018 SHALL have port o_Frame_Start  output  1  one-cycle pulse when pixel (0,0) begins.
REQ-019 SHALL have port o_RGB  output  3  pixel colour {R,G,B}.

Function
REQ-020 SHALL define H_TOTAL = sum of H_* (800), V_TOTAL = sum of V_* (525); both SHALL be at most 1024 and CLOCKS_PER_PIXEL at least 1.
REQ-021 SHALL run a divider 0..CLOCKS_PER_PIXEL-1 that wraps to 0; the pixel counters SHALL advance exactly on edges where the divider equals CLOCKS_PER_PIXEL-1.
REQ-022 On advance, o_X SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and o_Y SHALL increment; at (H_TOTAL-1, V_TOTAL-1) both SHALL wrap to 0.
REQ-023 All outputs SHALL be registered and mutually consistent in every cycle: decodes computed from the next counter values at the same edge.
REQ-024 o_Active SHALL be 1 iff o_X < H_ACTIVE and o_Y < V_ACTIVE.
REQ-025 o_Horizontal_Sync SHALL be 0 iff H_ACTIVE+H_FRONT <= o_X < H_ACTIVE+H_FRONT+H_SYNC (656..751).
REQ-026 o_Vertical_Sync SHALL be 0 iff V_ACTIVE+V_FRONT <= o_Y < V_ACTIVE+V_FRONT+V_SYNC (490..491).
REQ-027 o_Pixel_Enable SHALL be 1 only in the cycle following an advance; with CLOCKS_PER_PIXEL=1 it SHALL be constantly 1 after the first post-reset edge.
REQ-028 o_Frame_Start SHALL be 1 only in the single cycle where o_Pixel_Enable=1 and (o_X,o_Y)=(0,0); period H_TOTAL*V_TOTAL*CLOCKS_PER_PIXEL cycles (1,680,000).

Reset
REQ-029 While i_Reset=1 at an edge: divider 0, o_X=H_TOTAL-1, o_Y=V_TOTAL-1, o_Active 0, both syncs 1, o_Pixel_Enable 0, o_Frame_Start 0, o_RGB 000.
REQ-030 Reset asserted mid-frame SHALL take effect at the next edge with no partial line or sync completed.
REQ-031 After release, the CLOCKS_PER_PIXEL-th edge SHALL land on (0,0) with o_Pixel_Enable=1 and o_Frame_Start=1.

Configuration
REQ-032 With VGA_TEST_PATTERN_EN defined, o_RGB SHALL be o_X[9:7] (bars 0..4, 128 px wide) when o_Active=1, else 000.
REQ-033 Without VGA_TEST_PATTERN_EN, o_RGB SHALL be constant 000, port retained, all other behaviour identical.

Verification
REQ-034 Reset 3 cycles, release -> 4th edge: o_X=0, o_Y=0, o_Frame_Start=1, o_Pixel_Enable=1, o_Active=1; next cycle o_Frame_Start=0.
REQ-035 Run one line -> o_Pixel_Enable every 4 cycles; o_Horizontal_Sync low for exactly 384 cycles starting at o_X=656; o_Active low from o_X=640.
REQ-036 Run one frame -> o_Vertical_Sync low for exactly 1600 pixel periods (lines 490-491); next o_Frame_Start exactly 1,680,000 cycles after the first.
REQ-037 Assert i_Reset at o_X=300, o_Y=200 -> next edge o_X=799, o_Y=524, syncs 1; restart per REQ-031.
REQ-038 VGA_TEST_PATTERN_EN defined -> o_RGB=000 at x=0..127, 011 at x=384, 100 at x=600, 000 at x=700; undefined -> o_RGB always 000.
